// File: rtl/qbus_master_cycle_if.sv
// qbus_master_cycle_if: DMA request handshake plus FPGA-side QBUS control lines
interface qbus_master_cycle_if;
  logic        granted, req, busy, done, nxm;
  logic [1:0]  op;
  logic [21:0] addr;
  logic [15:0] wdata, rdata;
  logic        DALtx, TSYNC, TDIN, TDOUT, TWTBT, RRPLY;
  modport master (input granted, req, op, addr, wdata, RRPLY,
                  output busy, done, nxm, rdata, DALtx, TSYNC, TDIN, TDOUT, TWTBT);
  modport slave  (output granted, req, op, addr, wdata, RRPLY,
                  input busy, done, nxm, rdata, DALtx, TSYNC, TDIN, TDOUT, TWTBT);
endinterface

// File: rtl/qbus_master_cycle.sv
// qbus_master_cycle: runs one QBUS DATI/DATO/DATOB/DATIO transfer as bus master, with NXM timeout
module qbus_master_cycle #(
  parameter int ADDR_SETUP = 3,
  parameter int ADDR_HOLD  = 2,
  parameter int DATA_SETUP = 2,
  parameter int DATA_WAIT  = 3,
  parameter int TIMEOUT    = 200
) (
  input  logic                clk,
  input  logic                reset_n,
  qbus_master_cycle_if.master bus,
  inout  wire  [21:0]         DAL
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [3:0] {IDLE, WAITR, ASET, AHOLD, RDWAIT, RDSAMP, RDEND, WSET, WDOUT, WEND, FIN} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_rply_m, r_rply_s;
  logic [1:0]    r_op;
  logic [21:0]   r_addr, r_dal;
  logic [15:0]   r_wdata, r_rdata;
  logic          r_nxm, r_busy, r_done, r_daltx, r_tsync, r_tdin, r_tdout, r_twtbt;
  logic          w_write, w_expired, w_addr_ph, w_data_ph, w_nxm, w_sample;
  assign w_write   = r_op[0] ^ r_op[1];
  assign w_expired = r_cnt == CW'(TIMEOUT - 1);
  assign w_addr_ph = w_next inside {ASET, AHOLD};
  assign w_data_ph = w_next inside {WSET, WDOUT, WEND};
  always_comb begin
    w_next   = r_state;
    w_nxm    = 1'b0;
    w_sample = 1'b0;
    case (r_state)
      IDLE:   if (bus.req && bus.granted) w_next = WAITR;
      WAITR:  if (!r_rply_s) w_next = ASET; else if (w_expired) begin w_next = FIN; w_nxm = 1'b1; end
      ASET:   if (r_cnt == CW'(ADDR_SETUP - 1)) w_next = AHOLD;
      AHOLD:  if (r_cnt == CW'(ADDR_HOLD - 1)) w_next = w_write ? WSET : RDWAIT;
      RDWAIT: if (r_rply_s) w_next = RDSAMP; else if (w_expired) begin w_next = FIN; w_nxm = 1'b1; end
      RDSAMP: if (r_cnt == CW'(DATA_WAIT - 1)) begin w_next = RDEND; w_sample = 1'b1; end
      RDEND:  if (!r_rply_s) w_next = (r_op == 2'b11) ? WSET : FIN; else if (w_expired) begin w_next = FIN; w_nxm = 1'b1; end
      WSET:   if (r_cnt == CW'(DATA_SETUP - 1)) w_next = WDOUT;
      WDOUT:  if (r_rply_s) w_next = WEND; else if (w_expired) begin w_next = FIN; w_nxm = 1'b1; end
      WEND:   if (!r_rply_s) w_next = FIN; else if (w_expired) begin w_next = FIN; w_nxm = 1'b1; end
      default: w_next = IDLE;
    endcase
  end
  // bus drives are decoded from the next state so every pin comes straight off a flop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rply_m <= 1'b0;
      r_rply_s <= 1'b0;
      r_op     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_dal    <= '0;
      r_nxm    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_daltx  <= 1'b0;
      r_tsync  <= 1'b0;
      r_tdin   <= 1'b0;
      r_tdout  <= 1'b0;
      r_twtbt  <= 1'b0;
    end else begin
      r_rply_m <= bus.RRPLY;
      r_rply_s <= r_rply_m;
      r_state  <= w_next;
      r_cnt    <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      if (r_state == IDLE && w_next == WAITR) begin
        r_op    <= bus.op;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_nxm   <= 1'b0;
      end
      if (w_nxm) r_nxm <= 1'b1;
      if (w_sample) r_rdata <= DAL[15:0];
      r_dal   <= w_addr_ph ? r_addr : w_data_ph ? {6'd0, r_wdata} : '0;
      r_daltx <= w_addr_ph || w_data_ph;
      r_tsync <= w_next inside {AHOLD, RDWAIT, RDSAMP, RDEND, WSET, WDOUT, WEND};
      r_tdin  <= w_next inside {RDWAIT, RDSAMP};
      r_tdout <= w_next == WDOUT;
      r_twtbt <= (w_addr_ph && w_write) || (w_data_ph && r_op == 2'b10);
      r_busy  <= !(w_next inside {IDLE, FIN});
      r_done  <= w_next == FIN;
    end
  assign DAL       = r_daltx ? r_dal : 'z;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.nxm   = r_nxm;
  assign bus.rdata = r_rdata;
  assign bus.DALtx = r_daltx;
  assign bus.TSYNC = r_tsync;
  assign bus.TDIN  = r_tdin;
  assign bus.TDOUT = r_tdout;
  assign bus.TWTBT = r_twtbt;
endmodule

// File: doc/qbus_master_cycle.md
# qbus_master_cycle

Bus-master data-cycle sequencer for the QSIC FPGA: runs a single QBUS DATI, DATO, DATOB or DATIO transfer on the FPGA-side signals of the QBUS interface, as the initiator end of the cycles that our register blocks answer as responders. It sits between the DMA engine, which issues one request per word, and the QBUS interface pins (DAL/DALtx, TSYNC/TDIN/TDOUT/TWTBT out, RRPLY in). A reply timeout reports non-existent memory (NXM). Bus arbitration (DMR/DMG/SACK) is handled outside this block.

## Interface
- ADDR_SETUP, 3: cycles DAL holds the address before TSYNC asserts (≥150 ns).
- ADDR_HOLD, 2: cycles the address stays on DAL after TSYNC asserts (≥100 ns).
- DATA_SETUP, 2: cycles write data sits on DAL before TDOUT asserts (≥100 ns).
- DATA_WAIT, 3: cycles after synchronized RRPLY before read data is sampled (≥150 ns).
- TIMEOUT, 200: cycles to wait for an RRPLY edge before declaring NXM.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- granted  in  1  block currently owns the bus. Sampled only in IDLE.
- req  in  1  start a cycle. Sampled in IDLE when granted=1.
- op  in  2  cycle type: 00 DATI, 01 DATO, 10 DATOB, 11 DATIO. Latched with req.
- addr  in  22  byte address. Latched with req. addr[0] selects the byte for DATOB.
- wdata  in  16  write data. Latched with req.
- busy  out  1  high from request accept until done.
- done  out  1  one-cycle pulse when the cycle ends.
- nxm  out  1  valid with done: the cycle timed out.
- rdata  out  16  read data. Valid from done until the next req.
- DALtx  out  1  1 = FPGA drives DAL.
- DAL  inout  22  true-polarity DAL. Tri-stated when DALtx=0.
- TSYNC, TDIN, TDOUT, TWTBT  out  1 each  active-high bus drives.
- RRPLY  in  1  asynchronous, active-high reply from the interface.

## Operation
- RRPLY passes through a 2-flop synchronizer (rply_s). All decisions use rply_s.
- States: IDLE, WAITR, ASET, AHOLD, RDWAIT, RDSAMP, RDEND, WSET, WDOUT, WEND, FIN.
- IDLE: on req && granted, latch op, addr and wdata, set busy, then go to WAITR.
- WAITR: wait for rply_s=0, because the previous slave may still be replying.
  - The timeout counter runs here. Expiry goes to FIN with nxm=1.
- ASET: DALtx=1, DAL=addr, TWTBT=1 for DATO/DATOB (0 otherwise). Lasts ADDR_SETUP cycles, then go to AHOLD.
- AHOLD: TSYNC=1, address held for ADDR_HOLD cycles.
  - DATI/DATIO: drop DALtx and TWTBT, assert TDIN, go to RDWAIT.
  - DATO/DATOB: go to WSET.
- RDWAIT: wait for rply_s=1, or timeout leading to FIN with nxm=1.
- RDSAMP: count DATA_WAIT cycles, then latch rdata=DAL[15:0] and negate TDIN.
- RDEND: wait for rply_s=0 (timeout applies). Then go to WSET for DATIO, else FIN.
- WSET: DALtx=1, DAL[15:0]=wdata, upper DAL=0, TWTBT=1 only for DATOB (byte write). Lasts DATA_SETUP cycles.
- WDOUT: TDOUT=1 until rply_s=1 (timeout applies), then negate TDOUT.
- WEND: data held; wait for rply_s=0 (timeout applies).
- FIN: negate TSYNC, TDIN, TDOUT, TWTBT and DALtx. Pulse done, clear busy, go to IDLE.
- Timeout counter: 0 to TIMEOUT-1, cleared on every state entry. Reaching TIMEOUT-1 is expiry.
- The block does not drive BS7. I/O-page accesses require the full 22-bit address (bits 21:13 all 1).
- req while busy is ignored. req without granted stays in IDLE.

## Timing
- Reset (async, immediate) sets every output to 0 and DAL to high-Z, and releases all bus lines. A cycle in progress is abandoned with no done pulse.
- Latencies from the req-accept edge:
  - TSYNC asserts 1+ADDR_SETUP cycles later when rply_s is already 0.
  - TDIN asserts ADDR_HOLD cycles after TSYNC.
- RRPLY→rply_s latency is 2 cycles. RDSAMP adds DATA_WAIT, so data is sampled ≥ DATA_WAIT+2 cycles after the RRPLY edge.
- TDOUT never asserts with DALtx=0. DAL data stays valid ≥1 cycle after TDOUT negates.
- nxm cycles still pass through FIN, so TSYNC always negates before done.

## Test plan
- DATI to responder at 17777774 holding 123456 (3-cycle reply) → TSYNC then TDIN; done with rdata=123456, nxm=0; all bus lines 0 afterwards.
- DATO of 054321 to 17777774, then DATI → TWTBT=1 during address only; second cycle returns 054321.
- DATIO to 17777772: read 123456, write 054545 → one TSYNC assertion spans both TDIN and TDOUT; readback gives 054545.
- DATOB, addr=17777775, wdata=000377 → TWTBT=1 in both address and data phases; only the high byte changes.
- DATI to 17777770 with no responder → done with nxm=1 after TIMEOUT cycles in RDWAIT; TSYNC and TDIN negated.
- reset_n pulsed low mid-WDOUT → all outputs 0 and DAL high-Z immediately, no done; a following req runs normally. RRPLY held high at req → stays in WAITR with TSYNC=0 until released.
